// File: rtl/mem_cache_cmd_arbiter_rr.sv
// N-channel cache command arbiter: round-robin or fixed-priority grant,
// one outstanding memory transaction, response routed to the owning channel.
module mem_cache_cmd_arbiter_rr #(
  parameter int NCH  = 2,
  parameter int MODE = 0,
  parameter int AW   = 32,
  parameter int DW   = 32,
  parameter int MW   = 2,
  parameter int EW   = 2
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NCH-1:0]                req_in_valid,
  output logic [NCH-1:0]                req_in_ready,
  input  logic [NCH-1:0][AW-1:0]        req_in_addr,
  input  logic [NCH-1:0]                req_in_wen,
  input  logic [NCH-1:0][DW-1:0]        req_in_wdata,
  input  logic [NCH-1:0][MW-1:0]        req_in_wmask,
  input  logic [NCH-1:0]                req_in_pte,
  output logic [NCH-1:0]                resp_in_valid,
  output logic [NCH-1:0]                resp_in_error,
  output logic [NCH-1:0][EW-1:0]        resp_in_errty,
  output logic [NCH-1:0][DW-1:0]        resp_in_rdata,
  output logic                          memreq_in_valid,
  input  logic                          memreq_in_ready,
  output logic [AW-1:0]                 memreq_in_addr,
  output logic                          memreq_in_wen,
  output logic [DW-1:0]                 memreq_in_wdata,
  output logic [MW-1:0]                 memreq_in_wmask,
  output logic                          memreq_in_pte,
  input  logic                          memresp_in_valid,
  input  logic                          memresp_in_error,
  input  logic [EW-1:0]                 memresp_in_errty,
  input  logic [DW-1:0]                 memresp_in_rdata,
  output logic                          busy,
  output logic [$clog2(NCH)-1:0]        cur_ch
);

  localparam int CW = $clog2(NCH);
  localparam logic [MW-1:0] SIZE_W = MW'(2);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    WAIT = 2'd2
  } state_t;

  state_t          r_state;
  logic [CW-1:0]   r_last;
  logic [CW-1:0]   r_cur;
  logic [AW-1:0]   r_h_addr;
  logic            r_h_wen;
  logic [DW-1:0]   r_h_wdata;
  logic [MW-1:0]   r_h_wmask;
  logic            r_h_pte;

  logic [CW-1:0]   w_gnt;
  logic            w_ok;
  logic            w_issue;

  // Round-robin search starts one past the last granted channel.
  always_comb begin
    w_gnt = '0;
    w_ok  = 1'b0;
    if (MODE == 1) begin
      for (int i = NCH - 1; i >= 0; i--) begin
        if (req_in_valid[i]) begin
          w_ok  = 1'b1;
          w_gnt = CW'(i);
        end
      end
    end else begin
      for (int k = 1; k <= NCH; k++) begin
        if (!w_ok && req_in_valid[(int'(r_last) + k) % NCH]) begin
          w_ok  = 1'b1;
          w_gnt = CW'((int'(r_last) + k) % NCH);
        end
      end
    end
  end

  assign w_issue = (r_state == IDLE) && w_ok && !reset;

  always_comb begin
    req_in_ready = '0;
    if (w_issue)
      req_in_ready[w_gnt] = 1'b1;
  end

  always_comb begin
    memreq_in_valid = 1'b0;
    memreq_in_addr  = '0;
    memreq_in_wen   = 1'b0;
    memreq_in_wdata = '0;
    memreq_in_wmask = SIZE_W;
    memreq_in_pte   = 1'b0;
    unique case (r_state)
      IDLE: begin
        memreq_in_valid = w_issue;
        memreq_in_addr  = req_in_addr[w_gnt];
        memreq_in_wen   = req_in_wen[w_gnt];
        memreq_in_wdata = req_in_wdata[w_gnt];
        memreq_in_wmask = req_in_wmask[w_gnt];
        memreq_in_pte   = req_in_pte[w_gnt];
      end
      HOLD: begin
        memreq_in_valid = 1'b1;
        memreq_in_addr  = r_h_addr;
        memreq_in_wen   = r_h_wen;
        memreq_in_wdata = r_h_wdata;
        memreq_in_wmask = r_h_wmask;
        memreq_in_pte   = r_h_pte;
      end
      WAIT: begin
        memreq_in_valid = 1'b0;
      end
      default: begin
        memreq_in_valid = 1'b0;
      end
    endcase
  end

  // Error and data are broadcast; only valid is steered.
  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      resp_in_valid[i] = (r_state == WAIT) && memresp_in_valid
                         && (r_cur == CW'(i));
      resp_in_error[i] = memresp_in_error;
      resp_in_errty[i] = memresp_in_errty;
      resp_in_rdata[i] = memresp_in_rdata;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= IDLE;
      r_last    <= CW'(NCH - 1);
      r_cur     <= '0;
      r_h_addr  <= '0;
      r_h_wen   <= 1'b0;
      r_h_wdata <= '0;
      r_h_wmask <= '0;
      r_h_pte   <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (w_ok) begin
            r_h_addr  <= req_in_addr[w_gnt];
            r_h_wen   <= req_in_wen[w_gnt];
            r_h_wdata <= req_in_wdata[w_gnt];
            r_h_wmask <= req_in_wmask[w_gnt];
            r_h_pte   <= req_in_pte[w_gnt];
            r_cur     <= w_gnt;
            r_last    <= w_gnt;
            r_state   <= memreq_in_ready ? WAIT : HOLD;
          end
        end
        HOLD: begin
          if (memreq_in_ready)
            r_state <= WAIT;
        end
        WAIT: begin
          if (memresp_in_valid)
            r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign busy   = (r_state != IDLE);
  assign cur_ch = r_cur;

endmodule

// File: tb/tb_mem_cache_cmd_arbiter_rr.sv
// Directed bench: RR and fixed-priority 4-channel instances sharing stimulus,
// plus a 3-channel RR instance for non-power-of-two wrap.
module tb_mem_cache_cmd_arbiter_rr;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [3:0]        rv;
  logic [3:0][31:0]  addr;
  logic [3:0]        wen;
  logic [3:0][31:0]  wdata;
  logic [3:0][1:0]   wmask;
  logic [3:0]        pte;
  logic              mrdy, pv, perr;
  logic [1:0]        pety;
  logic [31:0]       prd;

  logic [3:0]        a_rdy, a_ov, a_oerr;
  logic [3:0][1:0]   a_oety;
  logic [3:0][31:0]  a_ord;
  logic              a_mv, a_mwen, a_mpte, a_busy;
  logic [31:0]       a_maddr, a_mwdata;
  logic [1:0]        a_mwmask, a_cur;

  logic [3:0]        b_rdy, b_ov, b_oerr;
  logic [3:0][1:0]   b_oety;
  logic [3:0][31:0]  b_ord;
  logic              b_mv, b_mwen, b_mpte, b_busy;
  logic [31:0]       b_maddr, b_mwdata;
  logic [1:0]        b_mwmask, b_cur;

  logic [2:0]        c_rv;
  logic [2:0][31:0]  c_addr, c_wdata;
  logic [2:0]        c_wen, c_pte;
  logic [2:0][1:0]   c_wmask;
  logic [2:0]        c_rdy, c_ov, c_oerr;
  logic [2:0][1:0]   c_oety;
  logic [2:0][31:0]  c_ord;
  logic              c_mv, c_mwen, c_mpte, c_busy;
  logic [31:0]       c_maddr, c_mwdata;
  logic [1:0]        c_mwmask, c_cur;

  mem_cache_cmd_arbiter_rr #(.NCH(4), .MODE(0)) u_a (
    .clk(clk), .reset(rst),
    .req_in_valid(rv), .req_in_ready(a_rdy), .req_in_addr(addr),
    .req_in_wen(wen), .req_in_wdata(wdata), .req_in_wmask(wmask),
    .req_in_pte(pte),
    .resp_in_valid(a_ov), .resp_in_error(a_oerr),
    .resp_in_errty(a_oety), .resp_in_rdata(a_ord),
    .memreq_in_valid(a_mv), .memreq_in_ready(mrdy),
    .memreq_in_addr(a_maddr), .memreq_in_wen(a_mwen),
    .memreq_in_wdata(a_mwdata), .memreq_in_wmask(a_mwmask),
    .memreq_in_pte(a_mpte),
    .memresp_in_valid(pv), .memresp_in_error(perr),
    .memresp_in_errty(pety), .memresp_in_rdata(prd),
    .busy(a_busy), .cur_ch(a_cur)
  );

  mem_cache_cmd_arbiter_rr #(.NCH(4), .MODE(1)) u_b (
    .clk(clk), .reset(rst),
    .req_in_valid(rv), .req_in_ready(b_rdy), .req_in_addr(addr),
    .req_in_wen(wen), .req_in_wdata(wdata), .req_in_wmask(wmask),
    .req_in_pte(pte),
    .resp_in_valid(b_ov), .resp_in_error(b_oerr),
    .resp_in_errty(b_oety), .resp_in_rdata(b_ord),
    .memreq_in_valid(b_mv), .memreq_in_ready(mrdy),
    .memreq_in_addr(b_maddr), .memreq_in_wen(b_mwen),
    .memreq_in_wdata(b_mwdata), .memreq_in_wmask(b_mwmask),
    .memreq_in_pte(b_mpte),
    .memresp_in_valid(pv), .memresp_in_error(perr),
    .memresp_in_errty(pety), .memresp_in_rdata(prd),
    .busy(b_busy), .cur_ch(b_cur)
  );

  mem_cache_cmd_arbiter_rr #(.NCH(3), .MODE(0)) u_c (
    .clk(clk), .reset(rst),
    .req_in_valid(c_rv), .req_in_ready(c_rdy), .req_in_addr(c_addr),
    .req_in_wen(c_wen), .req_in_wdata(c_wdata), .req_in_wmask(c_wmask),
    .req_in_pte(c_pte),
    .resp_in_valid(c_ov), .resp_in_error(c_oerr),
    .resp_in_errty(c_oety), .resp_in_rdata(c_ord),
    .memreq_in_valid(c_mv), .memreq_in_ready(mrdy),
    .memreq_in_addr(c_maddr), .memreq_in_wen(c_mwen),
    .memreq_in_wdata(c_mwdata), .memreq_in_wmask(c_mwmask),
    .memreq_in_pte(c_mpte),
    .memresp_in_valid(pv), .memresp_in_error(perr),
    .memresp_in_errty(pety), .memresp_in_rdata(prd),
    .busy(c_busy), .cur_ch(c_cur)
  );

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp)
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    else
      n_pass++;
  endtask

  initial begin
    logic [3:0] rr_seq [3];
    rr_seq[0] = 4'b0010;
    rr_seq[1] = 4'b1000;
    rr_seq[2] = 4'b0010;

    rst = 1'b1;
    rv = 4'hF;
    for (int i = 0; i < 4; i++) begin
      addr[i]  = 32'h1000 + 32'(i) * 32'h40;
      wdata[i] = 32'h5000 + 32'(i);
    end
    wen = '0; wmask = '0; pte = '0;
    mrdy = 1'b1; pv = 1'b0; perr = 1'b0; pety = '0; prd = '0;
    c_rv = '0; c_addr = '0; c_wdata = '0; c_wen = '0;
    c_pte = '0; c_wmask = '0;

    #2;
    chk("rst_busy", a_busy, 0);
    chk("rst_cur", a_cur, 0);
    chk("rst_rdy", a_rdy, 0);
    chk("rst_mv", a_mv, 0);
    chk("rst_ov", a_ov, 0);

    @(negedge clk);
    rst = 1'b0;
    #1;

    for (int t = 0; t < 5; t++) begin
      chk("rr_rdy", a_rdy, 4'b0001 << (t % 4));
      chk("rr_maddr", a_maddr, addr[t % 4]);
      chk("fp_rdy_all", b_rdy, 4'b0001);
      @(negedge clk);
      pv = 1'b1;
      prd = 32'hA000 + 32'(t);
      #1;
      chk("rr_cur", a_cur, t % 4);
      chk("rr_ov", a_ov, 4'b0001 << (t % 4));
      chk("rr_bcast", a_ord[(t + 1) % 4], 32'hA000 + 32'(t));
      chk("rr_busy", a_busy, 1);
      @(negedge clk);
      pv = 1'b0;
      #1;
    end

    rv = 4'b1010;
    #1;
    for (int t = 0; t < 3; t++) begin
      chk("fp_rdy", b_rdy, 4'b0010);
      chk("rr_alt", a_rdy, rr_seq[t]);
      @(negedge clk);
      pv = 1'b1;
      #1;
      chk("fp_cur", b_cur, 1);
      chk("fp_ov", b_ov, 4'b0010);
      @(negedge clk);
      pv = 1'b0;
      #1;
    end

    rv = 4'b0100;
    addr[2] = 32'h100;
    wen[2] = 1'b1;
    wdata[2] = 32'hDEADBEEF;
    mrdy = 1'b0;
    #1;
    chk("hold_gnt", a_rdy, 4'b0100);
    @(negedge clk);
    rv = 4'b0000;
    addr[2] = 32'h200;
    wen[2] = 1'b0;
    wdata[2] = 32'h0;
    #1;
    for (int h = 0; h < 3; h++) begin
      if (h == 2) mrdy = 1'b1;
      chk("hold_mv", a_mv, 1);
      chk("hold_addr", a_maddr, 32'h100);
      chk("hold_wdata", a_mwdata, 32'hDEADBEEF);
      chk("hold_wen", a_mwen, 1);
      chk("hold_rdy", a_rdy, 0);
      @(negedge clk);
      #1;
    end
    chk("wait_mv", a_mv, 0);
    chk("wait_wen", a_mwen, 0);
    chk("wait_wmask", a_mwmask, 2'd2);
    chk("wait_busy", a_busy, 1);
    pv = 1'b1; perr = 1'b1; pety = 2'b10; prd = 32'hBAD0;
    #1;
    chk("err_ov", a_ov, 4'b0100);
    chk("err_err", a_oerr[2], 1);
    chk("err_ety", a_oety[2], 2'b10);
    @(negedge clk);
    pv = 1'b0; perr = 1'b0; pety = '0;
    #1;

    rv = 4'b0010;
    #1;
    chk("rst_w_gnt", a_rdy, 4'b0010);
    @(negedge clk);
    #1;
    chk("rst_w_cur", a_cur, 1);
    chk("rst_w_busy", a_busy, 1);
    rst = 1'b1;
    rv = 4'hF;
    #1;
    chk("midrst_busy", a_busy, 0);
    chk("midrst_rdy", a_rdy, 0);
    chk("midrst_mv", a_mv, 0);
    @(negedge clk);
    rst = 1'b0;
    rv = 4'b0000;
    @(negedge clk);
    @(negedge clk);
    pv = 1'b1;
    #1;
    chk("late_ov", a_ov, 0);
    chk("late_busy", a_busy, 0);
    @(negedge clk);
    pv = 1'b0;
    rv = 4'hF;
    #1;
    chk("post_rst_gnt", a_rdy, 4'b0001);
    chk("post_rst_mv", a_mv, 1);
    rv = 4'b0000;

    c_rv = 3'b010;
    #1;
    chk("w3_first", c_rdy, 3'b010);
    @(negedge clk);
    pv = 1'b1;
    #1;
    chk("w3_cur1", c_cur, 1);
    chk("w3_ov1", c_ov, 3'b010);
    @(negedge clk);
    pv = 1'b0;
    c_rv = 3'b011;
    #1;
    chk("w3_wrap", c_rdy, 3'b001);
    @(negedge clk);
    pv = 1'b1;
    #1;
    chk("w3_cur0", c_cur, 0);
    chk("w3_ov0", c_ov, 3'b001);
    @(negedge clk);
    pv = 1'b0;
    #1;
    chk("w3_next", c_rdy, 3'b010);
    c_rv = 3'b000;

    @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
